// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: 4-bit character-LCD bus driver.
// Takes one byte plus register-select per wr_enable pulse, sends it as two
// nibbles (high first) with setup / E-high / hold / inter-nibble timing, waits
// out the controller execution time, then pulses wr_finish for one cycle.
// Optional feature macro: LCD_LONG_EXEC_EN -- when defined, clear display
// (0x01) and return home (0x02/0x03) commands get the T_EXEC_LONG wait.
// All outputs are registered; reset is asynchronous and active-high.
module lcd_nibble_writer #(
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_E_HIGH    = 12,
  parameter int unsigned T_HOLD      = 1,
  parameter int unsigned T_GAP       = 50,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_enable,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d,
  output logic       wr_finish,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE,
    HI_SETUP,
    HI_PULSE,
    HI_HOLD,
    GAP,
    LO_SETUP,
    LO_PULSE,
    LO_HOLD,
    EXEC,
    DONE
  } state_t;

  // Counter reload values: a state lasting T cycles loads T-1 and leaves at 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] E_LD     = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC - 1);

  // Reject timing parameters that are zero or do not fit the counter.
  generate
    if ((T_SETUP < 1) || (T_E_HIGH < 1) || (T_HOLD < 1) || (T_GAP < 1) ||
        (T_EXEC < 1) || (T_EXEC_LONG < 1) ||
        (64'(T_SETUP) >= (64'd1 << CNT_W)) || (64'(T_E_HIGH) >= (64'd1 << CNT_W)) ||
        (64'(T_HOLD) >= (64'd1 << CNT_W)) || (64'(T_GAP) >= (64'd1 << CNT_W)) ||
        (64'(T_EXEC) >= (64'd1 << CNT_W)) || (64'(T_EXEC_LONG) >= (64'd1 << CNT_W)))
    begin : g_param_check
      $error("lcd_nibble_writer: timing parameter out of range");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_dec;
  logic [CNT_W-1:0] exec_ld;
  logic [7:0]       data_reg, data_next;
  logic             rs_reg, rs_next;

  logic             lcd_e_reg, lcd_e_next;
  logic             lcd_rs_reg, lcd_rs_next;
  logic [3:0]       lcd_d_reg, lcd_d_next;
  logic             wr_finish_reg, wr_finish_next;
  logic             busy_reg, busy_next;

  assign cnt_dec = cnt_reg - CNT_W'(1);

`ifdef LCD_LONG_EXEC_EN
  localparam logic [CNT_W-1:0] EXEC_LONG_LD = CNT_W'(T_EXEC_LONG - 1);

  // Clear display and return home commands need the long execution wait.
  always_comb begin
    exec_ld = EXEC_LD;
    if (!rs_reg && ((data_reg == 8'h01) || (data_reg == 8'h02) || (data_reg == 8'h03))) begin
      exec_ld = EXEC_LONG_LD;
    end
  end
`else
  assign exec_ld = EXEC_LD;
`endif

  // Next-state, counter and latched-byte logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    rs_next    = rs_reg;
    case (state_reg)
      IDLE: begin
        if (wr_enable) begin
          state_next = HI_SETUP;
          cnt_next   = SETUP_LD;
          data_next  = data_in;
          rs_next    = rs_in;
        end
      end
      HI_SETUP: begin
        if (cnt_reg == '0) begin
          state_next = HI_PULSE;
          cnt_next   = E_LD;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      HI_PULSE: begin
        if (cnt_reg == '0) begin
          state_next = HI_HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      HI_HOLD: begin
        if (cnt_reg == '0) begin
          state_next = GAP;
          cnt_next   = GAP_LD;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      GAP: begin
        if (cnt_reg == '0) begin
          state_next = LO_SETUP;
          cnt_next   = SETUP_LD;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      LO_SETUP: begin
        if (cnt_reg == '0) begin
          state_next = LO_PULSE;
          cnt_next   = E_LD;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      LO_PULSE: begin
        if (cnt_reg == '0) begin
          state_next = LO_HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      LO_HOLD: begin
        if (cnt_reg == '0) begin
          state_next = EXEC;
          cnt_next   = exec_ld;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      EXEC: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // registered pins line up exactly with the state they belong to.
  always_comb begin
    lcd_e_next     = 1'b0;
    lcd_rs_next    = 1'b0;
    lcd_d_next     = 4'h0;
    wr_finish_next = 1'b0;
    busy_next      = (state_next != IDLE);
    case (state_next)
      HI_SETUP, HI_HOLD, GAP: begin
        lcd_d_next  = data_next[7:4];
        lcd_rs_next = rs_next;
      end
      HI_PULSE: begin
        lcd_d_next  = data_next[7:4];
        lcd_rs_next = rs_next;
        lcd_e_next  = 1'b1;
      end
      LO_SETUP, LO_HOLD, EXEC: begin
        lcd_d_next  = data_next[3:0];
        lcd_rs_next = rs_next;
      end
      LO_PULSE: begin
        lcd_d_next  = data_next[3:0];
        lcd_rs_next = rs_next;
        lcd_e_next  = 1'b1;
      end
      DONE: begin
        lcd_d_next     = data_next[3:0];
        lcd_rs_next    = rs_next;
        wr_finish_next = 1'b1;
      end
      default: begin
        lcd_d_next = 4'h0;
      end
    endcase
  end

  // State, counter, latched byte and output registers; reset clears all at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      data_reg      <= 8'h00;
      rs_reg        <= 1'b0;
      lcd_e_reg     <= 1'b0;
      lcd_rs_reg    <= 1'b0;
      lcd_d_reg     <= 4'h0;
      wr_finish_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      data_reg      <= data_next;
      rs_reg        <= rs_next;
      lcd_e_reg     <= lcd_e_next;
      lcd_rs_reg    <= lcd_rs_next;
      lcd_d_reg     <= lcd_d_next;
      wr_finish_reg <= wr_finish_next;
      busy_reg      <= busy_next;
    end
  end

  assign lcd_e     = lcd_e_reg;
  assign lcd_rs    = lcd_rs_reg;
  assign lcd_rw    = 1'b0;
  assign lcd_d     = lcd_d_reg;
  assign wr_finish = wr_finish_reg;
  assign busy      = busy_reg;

endmodule
